// File: rtl/fetch_unit_pkg.sv
// Fetch unit shared types and constants.
// FSM state encoding and PC increment step.
package fetch_unit_pkg;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } fetch_state_e;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_unit_pc_next_gen.sv
// Next-PC generator for the fetch unit.
// Pure combinational redirect and target arithmetic.
module pc_next_gen
  import fetch_unit_pkg::*;
#(
  parameter int dataW = 32
) (
  input  logic [dataW-1:0] pc,
  input  logic             always_branch,
  input  logic             test_branch,
  input  logic             absolute_branch,
  input  logic             branch_taken,
  input  logic [dataW-1:0] branch_addr,
  output logic [dataW-1:0] next_pc
);

  logic redirect;

  // Pick sequential, absolute or pc-relative target
  always_comb begin
    redirect = always_branch | (test_branch & branch_taken);
    next_pc  = pc + dataW'(PC_STEP);
    if (redirect) begin
      if (absolute_branch) begin
        next_pc = {branch_addr[dataW-1:1], 1'b0};
      end else begin
        next_pc = pc + branch_addr;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding request,
// buffers the word until the decoder consumes it.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int               dataW    = 32,
  parameter logic [dataW-1:0] RESET_PC = dataW'(32'h0000_0000)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [dataW-1:0] imemAddr,
  output logic             imemReq,
  input  logic             imemAck,
  input  logic [dataW-1:0] imemData,
  output logic [dataW-1:0] rawIns,
  output logic             insValid,
  input  logic             insReady,
  output logic [dataW-1:0] ProgAddr,
  output logic [dataW-1:0] LinkAddr,
  input  logic             AlwaysBranch,
  input  logic             TestBranch,
  input  logic             AbsoluteBranch,
  input  logic             BranchTaken,
  input  logic [dataW-1:0] BranchAddr,
  output logic             MisalignedFetch
);

  fetch_state_e     state_q, state_d;
  logic [dataW-1:0] pc_q, pc_d;
  logic [dataW-1:0] raw_q, raw_d;
  logic             mis_q, mis_d;
  logic [dataW-1:0] next_pc;

  pc_next_gen #(
    .dataW(dataW)
  ) u_pc_next_gen (
    .pc              (pc_q),
    .always_branch   (AlwaysBranch),
    .test_branch     (TestBranch),
    .absolute_branch (AbsoluteBranch),
    .branch_taken    (BranchTaken),
    .branch_addr     (BranchAddr),
    .next_pc         (next_pc)
  );

  // Next-state: capture on ack, advance PC on consume
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    raw_d   = raw_q;
    mis_d   = mis_q;
    unique case (state_q)
      S_REQ: begin
        if (imemAck) begin
          raw_d   = imemData;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (insReady) begin
          pc_d    = next_pc;
          state_d = S_REQ;
          if (next_pc[1:0] != 2'b00) begin
            mis_d = 1'b1;
          end
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      raw_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      raw_q   <= raw_d;
      mis_q   <= mis_d;
    end
  end

  // Handshake outputs are silenced while reset is held
  always_comb begin
    imemReq  = (state_q == S_REQ) && !reset;
    insValid = (state_q == S_HOLD) && !reset;
  end

  assign imemAddr        = pc_q;
  assign ProgAddr        = pc_q;
  assign LinkAddr        = pc_q + dataW'(PC_STEP);
  assign rawIns          = raw_q;
  assign MisalignedFetch = mis_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// Randomized handshakes against a PC/memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imemAddr;
  logic        imemReq;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] rawIns;
  logic        insValid;
  logic        insReady;
  logic [31:0] ProgAddr;
  logic [31:0] LinkAddr;
  logic        AlwaysBranch;
  logic        TestBranch;
  logic        AbsoluteBranch;
  logic        BranchTaken;
  logic [31:0] BranchAddr;
  logic        MisalignedFetch;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_pc;
  logic        exp_mis;

  logic [31:0] obs_addr;
  logic [31:0] obs_raw;
  logic [31:0] obs_pc;
  logic [31:0] obs_link;
  logic        obs_valid;
  logic        obs_mis;
  logic        obs_stable;

  fetch_unit #(
    .dataW    (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imemAddr        (imemAddr),
    .imemReq         (imemReq),
    .imemAck         (imemAck),
    .imemData        (imemData),
    .rawIns          (rawIns),
    .insValid        (insValid),
    .insReady        (insReady),
    .ProgAddr        (ProgAddr),
    .LinkAddr        (LinkAddr),
    .AlwaysBranch    (AlwaysBranch),
    .TestBranch      (TestBranch),
    .AbsoluteBranch  (AbsoluteBranch),
    .BranchTaken     (BranchTaken),
    .BranchAddr      (BranchAddr),
    .MisalignedFetch (MisalignedFetch)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  // Architectural PC rule: taken branch goes to target, else +4
  function automatic logic [31:0] model_next(
    input logic [31:0] pc, input logic ab, input logic tb,
    input logic abs_, input logic tk, input logic [31:0] ba);
    logic [31:0] t;
    if (ab || (tb && tk)) begin
      if (abs_) t = ba & 32'hFFFF_FFFE;
      else      t = pc + ba;
    end else begin
      t = pc + 32'd4;
    end
    return t;
  endfunction

  task automatic rand_br();
    AlwaysBranch   = 1'($urandom);
    TestBranch     = 1'($urandom);
    AbsoluteBranch = 1'($urandom);
    BranchTaken    = 1'($urandom);
    BranchAddr     = $urandom;
  endtask

  // Drives one fetch+consume; records observations only
  task automatic fetch_one(
    input int ack_wait, input int rdy_wait,
    input logic ab, input logic tb, input logic abs_,
    input logic tk, input logic [31:0] ba);
    obs_stable = 1'b1;
    insReady   = 1'b0;
    imemAck    = 1'b0;
    rand_br();
    #1;
    obs_addr = imemAddr;
    for (int i = 0; i < ack_wait; i++) begin
      rand_br();
      #1;
      if (imemAddr !== obs_addr || imemReq !== 1'b1 ||
          insValid !== 1'b0)
        obs_stable = 1'b0;
      @(posedge clk); #1;
    end
    imemAck  = 1'b1;
    imemData = mem_word(obs_addr);
    #1;
    if (imemReq !== 1'b1 || insValid !== 1'b0 ||
        imemAddr !== obs_addr)
      obs_stable = 1'b0;
    @(posedge clk); #1;
    imemAck  = 1'b0;
    imemData = $urandom;
    #1;
    obs_raw  = rawIns;
    obs_pc   = ProgAddr;
    obs_link = LinkAddr;
    for (int i = 0; i < rdy_wait; i++) begin
      rand_br();
      #1;
      if (insValid !== 1'b1 || imemReq !== 1'b0 ||
          rawIns !== obs_raw || ProgAddr !== obs_pc ||
          imemAddr !== obs_addr)
        obs_stable = 1'b0;
      @(posedge clk); #1;
    end
    insReady       = 1'b1;
    AlwaysBranch   = ab;
    TestBranch     = tb;
    AbsoluteBranch = abs_;
    BranchTaken    = tk;
    BranchAddr     = ba;
    #1;
    obs_valid = insValid;
    if (imemReq !== 1'b0) obs_stable = 1'b0;
    @(posedge clk); #1;
    insReady = 1'b0;
    rand_br();
    #1;
    obs_mis = MisalignedFetch;
    exp_pc  = model_next(exp_pc, ab, tb, abs_, tk, ba);
    if (exp_pc[1:0] != 2'b00) exp_mis = 1'b1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    insReady = 1'b0;
    imemData = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      imemAck = 1'($urandom);
      @(posedge clk); #1;
    end
    checks += 5;
    if (imemReq !== 1'b0) begin
      errors++; $display("FAIL rst_req got=%b exp=0", imemReq);
    end
    if (insValid !== 1'b0) begin
      errors++; $display("FAIL rst_valid got=%b exp=0", insValid);
    end
    if (rawIns !== 32'h0) begin
      errors++; $display("FAIL rst_raw got=%h exp=0", rawIns);
    end
    if (ProgAddr !== 32'h0) begin
      errors++; $display("FAIL rst_pc got=%h exp=0", ProgAddr);
    end
    if (MisalignedFetch !== 1'b0) begin
      errors++; $display("FAIL rst_mis got=%b exp=0", MisalignedFetch);
    end
    imemAck = 1'b0;
    reset   = 1'b0;
    #1;
    checks += 2;
    if (imemReq !== 1'b1) begin
      errors++; $display("FAIL first_req got=%b exp=1", imemReq);
    end
    if (imemAddr !== 32'h0) begin
      errors++; $display("FAIL first_addr got=%h exp=0", imemAddr);
    end
    exp_pc  = 32'h0;
    exp_mis = 1'b0;
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] want;
      want = 32'(k * 4);
      fetch_one(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checks += 4;
      if (obs_addr !== want) begin
        errors++; $display("FAIL seq_addr got=%h exp=%h", obs_addr, want);
      end
      if (obs_raw !== mem_word(want)) begin
        errors++; $display("FAIL seq_raw got=%h exp=%h", obs_raw, mem_word(want));
      end
      if (obs_valid !== 1'b1) begin
        errors++; $display("FAIL seq_valid got=%b exp=1", obs_valid);
      end
      if (obs_stable !== 1'b1) begin
        errors++; $display("FAIL seq_hs got=%b exp=1", obs_stable);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] want;
    want = exp_pc;
    fetch_one(3, 5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks += 3;
    if (obs_stable !== 1'b1) begin
      errors++; $display("FAIL stall_stable got=%b exp=1", obs_stable);
    end
    if (obs_addr !== want) begin
      errors++; $display("FAIL stall_addr got=%h exp=%h", obs_addr, want);
    end
    if (obs_raw !== mem_word(want)) begin
      errors++; $display("FAIL stall_raw got=%h exp=%h", obs_raw, mem_word(want));
    end
  endtask

  task automatic test_branches();
    fetch_one(0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100);
    fetch_one(1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0);
    checks += 2;
    if (obs_addr !== 32'h100) begin
      errors++; $display("FAIL br_at100 got=%h exp=100", obs_addr);
    end
    if (exp_pc !== 32'hF0 || imemAddr !== 32'hF0) begin
      errors++; $display("FAIL br_taken got=%h exp=000000f0", imemAddr);
    end
    fetch_one(0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0101);
    fetch_one(0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0);
    checks += 1;
    if (imemAddr !== 32'h104) begin
      errors++; $display("FAIL br_nottaken got=%h exp=00000104", imemAddr);
    end
    fetch_one(0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0200);
    fetch_one(2, 2, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1235);
    checks += 3;
    if (obs_link !== 32'h204) begin
      errors++; $display("FAIL br_link got=%h exp=00000204", obs_link);
    end
    if (imemAddr !== 32'h1234) begin
      errors++; $display("FAIL br_abs got=%h exp=00001234", imemAddr);
    end
    if (obs_mis !== 1'b0) begin
      errors++; $display("FAIL br_mis got=%b exp=0", obs_mis);
    end
  endtask

  task automatic test_wrap();
    fetch_one(0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
    fetch_one(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks += 2;
    if (obs_link !== 32'h0) begin
      errors++; $display("FAIL wrap_link got=%h exp=0", obs_link);
    end
    if (imemAddr !== 32'h0) begin
      errors++; $display("FAIL wrap_pc got=%h exp=0", imemAddr);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      logic [31:0] want;
      logic [31:0] ba;
      want = exp_pc;
      ba   = $urandom & 32'hFFFF_FFFC;
      fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), ba);
      checks += 6;
      if (obs_addr !== want) begin
        errors++; $display("FAIL rnd_addr got=%h exp=%h", obs_addr, want);
      end
      if (obs_raw !== mem_word(want)) begin
        errors++; $display("FAIL rnd_raw got=%h exp=%h", obs_raw, mem_word(want));
      end
      if (obs_link !== want + 32'd4) begin
        errors++; $display("FAIL rnd_link got=%h exp=%h", obs_link, want + 32'd4);
      end
      if (obs_valid !== 1'b1) begin
        errors++; $display("FAIL rnd_valid got=%b exp=1", obs_valid);
      end
      if (obs_stable !== 1'b1) begin
        errors++; $display("FAIL rnd_hs got=%b exp=1", obs_stable);
      end
      if (obs_mis !== exp_mis) begin
        errors++; $display("FAIL rnd_mis got=%b exp=%b", obs_mis, exp_mis);
      end
    end
    checks += 1;
    if (imemAddr !== exp_pc) begin
      errors++; $display("FAIL rnd_final got=%h exp=%h", imemAddr, exp_pc);
    end
  endtask

  task automatic test_misaligned();
    fetch_one(0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0010);
    fetch_one(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0002);
    checks += 2;
    if (imemAddr !== 32'h12) begin
      errors++; $display("FAIL mis_addr got=%h exp=00000012", imemAddr);
    end
    if (obs_mis !== 1'b1) begin
      errors++; $display("FAIL mis_set got=%b exp=1", obs_mis);
    end
    fetch_one(1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0300);
    fetch_one(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks += 2;
    if (obs_addr !== 32'h300) begin
      errors++; $display("FAIL mis_fetch got=%h exp=00000300", obs_addr);
    end
    if (MisalignedFetch !== 1'b1) begin
      errors++; $display("FAIL mis_sticky got=%b exp=1", MisalignedFetch);
    end
  endtask

  task automatic test_reset_mid_req();
    imemAck = 1'b0;
    @(posedge clk); #1;
    reset    = 1'b1;
    imemAck  = 1'b0;
    @(posedge clk); #1;
    imemAck  = 1'b1;
    imemData = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    reset = 1'b0;
    imemAck = 1'b0;
    #1;
    exp_pc  = 32'h0;
    exp_mis = 1'b0;
    checks += 5;
    if (imemAddr !== 32'h0) begin
      errors++; $display("FAIL mrst_addr got=%h exp=0", imemAddr);
    end
    if (imemReq !== 1'b1) begin
      errors++; $display("FAIL mrst_req got=%b exp=1", imemReq);
    end
    if (insValid !== 1'b0) begin
      errors++; $display("FAIL mrst_valid got=%b exp=0", insValid);
    end
    if (rawIns !== 32'h0) begin
      errors++; $display("FAIL mrst_raw got=%h exp=0", rawIns);
    end
    if (MisalignedFetch !== 1'b0) begin
      errors++; $display("FAIL mrst_mis got=%b exp=0", MisalignedFetch);
    end
    fetch_one(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checks += 2;
    if (obs_addr !== 32'h0) begin
      errors++; $display("FAIL mrst_fetch got=%h exp=0", obs_addr);
    end
    if (obs_raw !== mem_word(32'h0)) begin
      errors++; $display("FAIL mrst_raw2 got=%h exp=%h", obs_raw, mem_word(32'h0));
    end
  endtask

  initial begin
    reset          = 1'b1;
    imemAck        = 1'b0;
    imemData       = 32'h0;
    insReady       = 1'b0;
    AlwaysBranch   = 1'b0;
    TestBranch     = 1'b0;
    AbsoluteBranch = 1'b0;
    BranchTaken    = 1'b0;
    BranchAddr     = 32'h0;
    exp_pc         = 32'h0;
    exp_mis        = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_branches();
    test_wrap();
    test_random();
    test_misaligned();
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
